// File: rtl/pool_out_pkg.sv
// pool_out_pkg: shared definitions for the pooling output packer.
// Holds the controller state encoding and a ceiling-log2 helper used to size
// lane counters and FIFO pointers.
package pool_out_pkg;

  // Controller states
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// pool_out_fifo: synchronous FIFO with full/empty flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and data (ignored when full)
//   pop               read request (ignored when empty)
//   head_data         value of the head slot (valid when !empty)
//   full, empty       occupancy flags
module pool_out_fifo
  import pool_out_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  // A depth-1 FIFO still needs a 1-bit pointer to keep the index legal.
  localparam int PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + 1'b1;
    end
    return n;
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pool_out_packer.sv
// pool_out_packer: packs the pooled-data beat stream and the sparsity-flag
// beat stream into PORT_WIDTH words, each path through its own output FIFO.
// On layer_fnh the partial words are zero-padded and flushed, both FIFOs are
// drained, and clear_up pulses for one cycle.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   layer_fnh / clear_up             layer finished in / flush complete out
//   BF_val/BF_rdy/BF_data            data beat input handshake
//   BF_flg_val/BF_flg_rdy/BF_flg_data flag beat input handshake
//   POOLIF_val/IFPOOL_rdy/POOLIF_data packed data word output handshake
//   POOLIF_flg_val/IFPOOL_flg_rdy/POOLIF_flg_data packed flag word output
// Optional (macro POOL_OUT_STAT_EN): stat_words, stat_flg_words give the
//   number of words popped per path this layer, saturating at 16'hFFFF.
module pool_out_packer
  import pool_out_pkg::*;
#(
  parameter int PORT_WIDTH = 128,
  parameter int DATA_WIDTH = 8,
  parameter int FLAG_WIDTH = 32,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  layer_fnh,
  output logic                  clear_up,
  output logic                  BF_rdy,
  input  logic                  BF_val,
  input  logic [DATA_WIDTH-1:0] BF_data,
  output logic                  BF_flg_rdy,
  input  logic                  BF_flg_val,
  input  logic [FLAG_WIDTH-1:0] BF_flg_data,
  input  logic                  IFPOOL_rdy,
  output logic                  POOLIF_val,
  output logic [PORT_WIDTH-1:0] POOLIF_data,
  input  logic                  IFPOOL_flg_rdy,
  output logic                  POOLIF_flg_val,
  output logic [PORT_WIDTH-1:0] POOLIF_flg_data
`ifdef POOL_OUT_STAT_EN
  ,
  output logic [15:0]           stat_words,
  output logic [15:0]           stat_flg_words
`endif
);

  localparam int DATA_LANES = PORT_WIDTH / DATA_WIDTH;
  localparam int FLAG_LANES = PORT_WIDTH / FLAG_WIDTH;
  localparam int DCW = (clog2(DATA_LANES) > 0) ? clog2(DATA_LANES) : 1;
  localparam int FCW = (clog2(FLAG_LANES) > 0) ? clog2(FLAG_LANES) : 1;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;

  logic [DCW-1:0]        dcnt_r;
  logic [PORT_WIDTH-1:0] dpack_r;
  logic [PORT_WIDTH-1:0] dword_s;
  logic [PORT_WIDTH-1:0] dpush_data_s;
  logic                  dacc_s, dlast_s, dflush_s, dpush_s, dpop_s;
  logic                  dfull_s, dempty_s;

  logic [FCW-1:0]        fcnt_r;
  logic [PORT_WIDTH-1:0] fpack_r;
  logic [PORT_WIDTH-1:0] fword_s;
  logic [PORT_WIDTH-1:0] fpush_data_s;
  logic                  facc_s, flast_s, fflush_s, fpush_s, fpop_s;
  logic                  ffull_s, fempty_s;

  assign BF_rdy         = (state_r == ST_RUN) & ~dfull_s;
  assign BF_flg_rdy     = (state_r == ST_RUN) & ~ffull_s;
  assign clear_up       = (state_r == ST_DONE);
  assign POOLIF_val     = ~dempty_s;
  assign POOLIF_flg_val = ~fempty_s;

  assign dacc_s   = BF_val & BF_rdy;
  assign dlast_s  = (dcnt_r == DCW'(DATA_LANES - 1));
  assign dflush_s = (state_r == ST_FLUSH) & (dcnt_r != '0) & ~dfull_s;
  assign dpush_s  = (dacc_s & dlast_s) | dflush_s;
  assign dpop_s   = POOLIF_val & IFPOOL_rdy;

  assign facc_s   = BF_flg_val & BF_flg_rdy;
  assign flast_s  = (fcnt_r == FCW'(FLAG_LANES - 1));
  assign fflush_s = (state_r == ST_FLUSH) & (fcnt_r != '0) & ~ffull_s;
  assign fpush_s  = (facc_s & flast_s) | fflush_s;
  assign fpop_s   = POOLIF_flg_val & IFPOOL_flg_rdy;

  // Data word with the incoming beat merged into lane dcnt
  always_comb begin
    dword_s = dpack_r;
    dword_s[int'(dcnt_r)*DATA_WIDTH +: DATA_WIDTH] = BF_data;
    if (dacc_s) begin
      dpush_data_s = dword_s;
    end else begin
      dpush_data_s = dpack_r;
    end
  end

  // Flag word with the incoming beat merged into lane fcnt
  always_comb begin
    fword_s = fpack_r;
    fword_s[int'(fcnt_r)*FLAG_WIDTH +: FLAG_WIDTH] = BF_flg_data;
    if (facc_s) begin
      fpush_data_s = fword_s;
    end else begin
      fpush_data_s = fpack_r;
    end
  end

  // Data pack register and lane counter; lanes above dcnt stay zero, so a
  // flush pushes an already zero-padded word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_r  <= '0;
      dpack_r <= '0;
    end else if (dacc_s) begin
      if (dlast_s) begin
        dcnt_r  <= '0;
        dpack_r <= '0;
      end else begin
        dcnt_r  <= dcnt_r + 1'b1;
        dpack_r <= dword_s;
      end
    end else if (dflush_s) begin
      dcnt_r  <= '0;
      dpack_r <= '0;
    end
  end

  // Flag pack register and lane counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_r  <= '0;
      fpack_r <= '0;
    end else if (facc_s) begin
      if (flast_s) begin
        fcnt_r  <= '0;
        fpack_r <= '0;
      end else begin
        fcnt_r  <= fcnt_r + 1'b1;
        fpack_r <= fword_s;
      end
    end else if (fflush_s) begin
      fcnt_r  <= '0;
      fpack_r <= '0;
    end
  end

  // Layer-finish sequencing: flush partials, drain FIFOs, pulse clear_up
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (layer_fnh) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Counters are checked as registered, so FLUSH lasts at least a cycle
        if ((dcnt_r == '0) && (fcnt_r == '0)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (dempty_s && fempty_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  pool_out_fifo #(
    .WIDTH (PORT_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dpush_s),
    .push_data (dpush_data_s),
    .pop       (dpop_s),
    .head_data (POOLIF_data),
    .full      (dfull_s),
    .empty     (dempty_s)
  );

  pool_out_fifo #(
    .WIDTH (PORT_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_flag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fpush_s),
    .push_data (fpush_data_s),
    .pop       (fpop_s),
    .head_data (POOLIF_flg_data),
    .full      (ffull_s),
    .empty     (fempty_s)
  );

`ifdef POOL_OUT_STAT_EN
  logic [15:0] stat_words_r;
  logic [15:0] stat_flg_words_r;

  assign stat_words     = stat_words_r;
  assign stat_flg_words = stat_flg_words_r;

  // Per-layer pop counters; cleared as DONE hands back to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_r     <= 16'h0000;
      stat_flg_words_r <= 16'h0000;
    end else if (state_r == ST_DONE) begin
      stat_words_r     <= 16'h0000;
      stat_flg_words_r <= 16'h0000;
    end else begin
      if (dpop_s && (stat_words_r != 16'hFFFF)) begin
        stat_words_r <= stat_words_r + 16'h0001;
      end
      if (fpop_s && (stat_flg_words_r != 16'hFFFF)) begin
        stat_flg_words_r <= stat_flg_words_r + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pool_out_packer.sv
// Testbench for pool_out_packer with default parameters (128/8/32, depth 2).
module tb_pool_out_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         layer_fnh;
  logic         clear_up;
  logic         BF_rdy, BF_val;
  logic [7:0]   BF_data;
  logic         BF_flg_rdy, BF_flg_val;
  logic [31:0]  BF_flg_data;
  logic         IFPOOL_rdy, POOLIF_val;
  logic [127:0] POOLIF_data;
  logic         IFPOOL_flg_rdy, POOLIF_flg_val;
  logic [127:0] POOLIF_flg_data;
`ifdef POOL_OUT_STAT_EN
  logic [15:0]  stat_words, stat_flg_words;
`endif

  always #5 clk = ~clk;

  pool_out_packer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .layer_fnh       (layer_fnh),
    .clear_up        (clear_up),
    .BF_rdy          (BF_rdy),
    .BF_val          (BF_val),
    .BF_data         (BF_data),
    .BF_flg_rdy      (BF_flg_rdy),
    .BF_flg_val      (BF_flg_val),
    .BF_flg_data     (BF_flg_data),
    .IFPOOL_rdy      (IFPOOL_rdy),
    .POOLIF_val      (POOLIF_val),
    .POOLIF_data     (POOLIF_data),
    .IFPOOL_flg_rdy  (IFPOOL_flg_rdy),
    .POOLIF_flg_val  (POOLIF_flg_val),
    .POOLIF_flg_data (POOLIF_flg_data)
`ifdef POOL_OUT_STAT_EN
    ,
    .stat_words      (stat_words),
    .stat_flg_words  (stat_flg_words)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int clear_cnt = 0;
  int d_acc = 0;
  int d_pops = 0;
  int f_pops = 0;
  bit fnh_live = 1'b0;

  // Reference model: beats collected per path, completed words queued
  logic [7:0]   dpart[$];
  logic [31:0]  fpart[$];
  logic [127:0] exp_d[$];
  logic [127:0] exp_f[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_dword();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < dpart.size(); i++) w = w | (128'(dpart[i]) << (8 * i));
    exp_d.push_back(w);
    dpart.delete();
  endtask

  task automatic m_fword();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < fpart.size(); i++) w = w | (128'(fpart[i]) << (32 * i));
    exp_f.push_back(w);
    fpart.delete();
  endtask

  task automatic m_reset();
    dpart.delete(); fpart.delete(); exp_d.delete(); exp_f.delete();
  endtask

  // One clock: score handshakes seen before the edge, then advance to edge+1
  task automatic tick();
    bit acc_d, acc_f;
    acc_d = BF_val && BF_rdy;
    acc_f = BF_flg_val && BF_flg_rdy;
    if (POOLIF_val && IFPOOL_rdy) begin
      d_pops++;
      if (exp_d.size() == 0) check("d_spurious", 128'd1, 128'd0);
      else check("d_word", POOLIF_data, exp_d.pop_front());
    end
    if (POOLIF_flg_val && IFPOOL_flg_rdy) begin
      f_pops++;
      if (exp_f.size() == 0) check("f_spurious", 128'd1, 128'd0);
      else check("f_word", POOLIF_flg_data, exp_f.pop_front());
    end
    if (clear_up) clear_cnt++;
    if (acc_d) begin
      d_acc++;
      dpart.push_back(BF_data);
      if (dpart.size() == 16) m_dword();
    end
    if (acc_f) begin
      fpart.push_back(BF_flg_data);
      if (fpart.size() == 4) m_fword();
    end
    if (layer_fnh && fnh_live) begin
      if (dpart.size() != 0) m_dword();
      if (fpart.size() != 0) m_fword();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_val"}, 128'(POOLIF_val), 128'd0);
    check({tag, "_fval"}, 128'(POOLIF_flg_val), 128'd0);
    check({tag, "_data"}, POOLIF_data, 128'd0);
    check({tag, "_fdata"}, POOLIF_flg_data, 128'd0);
    check({tag, "_clr"}, 128'(clear_up), 128'd0);
    check({tag, "_rdy"}, 128'(BF_rdy), 128'd1);
    check({tag, "_frdy"}, 128'(BF_flg_rdy), 128'd1);
  endtask

  // Run with both output readies high until the model queues and DUT are empty
  task automatic drain(input string tag);
    int g;
    IFPOOL_rdy = 1'b1; IFPOOL_flg_rdy = 1'b1;
    g = 0;
    while ((exp_d.size() != 0 || exp_f.size() != 0 || POOLIF_val || POOLIF_flg_val) && g < 60) begin
      tick(); g++;
    end
    check({tag, "_drained"}, 128'(exp_d.size() + exp_f.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g, clr0, dp0;
    rst_n = 1'b0; layer_fnh = 1'b0;
    BF_val = 1'b0; BF_data = '0; BF_flg_val = 1'b0; BF_flg_data = '0;
    IFPOOL_rdy = 1'b1; IFPOOL_flg_rdy = 1'b1;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1: sixteen bytes back to back form one word, valid right after
    for (int i = 0; i < 16; i++) begin
      BF_val = 1'b1; BF_data = 8'(i);
      if (i == 15) check("t1_val_early", 128'(POOLIF_val), 128'd0);
      tick();
    end
    BF_val = 1'b0;
    check("t1_val", 128'(POOLIF_val), 128'd1);
    check("t1_word", POOLIF_data, 128'h0F0E0D0C0B0A09080706050403020100);
    tick();
    check("t1_val_after", 128'(POOLIF_val), 128'd0);

    // 2: four flag beats; data path stays idle
    for (int i = 0; i < 4; i++) begin
      BF_flg_val = 1'b1; BF_flg_data = 32'h11111111 * 32'(i + 1);
      tick();
    end
    BF_flg_val = 1'b0;
    check("t2_fval", 128'(POOLIF_flg_val), 128'd1);
    check("t2_fword", POOLIF_flg_data, 128'h44444444333333332222222211111111);
    check("t2_dval", 128'(POOLIF_val), 128'd0);
    tick();

    // 3: backpressure: 32 bytes fill the FIFO, rest waits for IFPOOL_rdy
    IFPOOL_rdy = 1'b0;
    base = d_acc; dp0 = d_pops;
    for (int i = 0; i < 40; i++) begin
      BF_val = 1'b1; BF_data = 8'($urandom);
      tick();
    end
    check("t3_accepted_full", 128'(d_acc - base), 128'd32);
    check("t3_rdy_low", 128'(BF_rdy), 128'd0);
    IFPOOL_rdy = 1'b1;
    g = 0;
    while ((d_acc - base) < 48 && g < 100) begin
      BF_data = 8'($urandom); tick(); g++;
    end
    BF_val = 1'b0;
    check("t3_accepted_all", 128'(d_acc - base), 128'd48);
    drain("t3");
    check("t3_pops", 128'(d_pops - dp0), 128'd3);

    // 4: partial words flushed zero-padded, clear_up only after both popped
    IFPOOL_rdy = 1'b0; IFPOOL_flg_rdy = 1'b0;
    clr0 = clear_cnt;
    for (int i = 0; i < 5; i++) begin
      BF_val = 1'b1; BF_data = 8'hA1 + 8'(i);
      BF_flg_val = (i == 0); BF_flg_data = 32'hDEADBEEF;
      tick();
    end
    BF_val = 1'b0; BF_flg_val = 1'b0;
    layer_fnh = 1'b1; fnh_live = 1'b1;
    tick();
    layer_fnh = 1'b0; fnh_live = 1'b0;
    check("t4_rdy_flush", 128'(BF_rdy), 128'd0);
    repeat (4) tick();
    check("t4_dword", POOLIF_data, 128'h000000A5A4A3A2A1);
    check("t4_fword", POOLIF_flg_data, 128'h000000000000000000000000DEADBEEF);
    check("t4_rdy_drain", 128'(BF_rdy), 128'd0);
    check("t4_frdy_drain", 128'(BF_flg_rdy), 128'd0);
    check("t4_no_clear_yet", 128'(clear_cnt - clr0), 128'd0);
    IFPOOL_rdy = 1'b1; IFPOOL_flg_rdy = 1'b1;
    g = 0;
    while (clear_up !== 1'b1 && g < 20) begin
      tick(); g++;
    end
    check("t4_clear_seen", 128'(clear_up), 128'd1);
    check("t4_popped_first", 128'(exp_d.size() + exp_f.size()), 128'd0);
    tick();
    check("t4_clear_once", 128'(clear_cnt - clr0), 128'd1);
    check("t4_rdy_after", 128'(BF_rdy), 128'd1);
    check("t4_clear_low", 128'(clear_up), 128'd0);

    // 5: empty flush: clear_up at t+3; layer_fnh during DRAIN ignored
    clr0 = clear_cnt; dp0 = d_pops;
    layer_fnh = 1'b1; fnh_live = 1'b1;
    tick();
    layer_fnh = 1'b0; fnh_live = 1'b0;
    check("t5_clr_t1", 128'(clear_up), 128'd0);
    tick();
    check("t5_clr_t2", 128'(clear_up), 128'd0);
    layer_fnh = 1'b1;
    tick();
    layer_fnh = 1'b0;
    check("t5_clr_t3", 128'(clear_up), 128'd1);
    repeat (6) tick();
    check("t5_clear_count", 128'(clear_cnt - clr0), 128'd1);
    check("t5_rdy", 128'(BF_rdy), 128'd1);
    check("t5_no_words", 128'(d_pops - dp0), 128'd0);

    // 6: reset during FLUSH discards everything, no clear_up
    IFPOOL_rdy = 1'b0; clr0 = clear_cnt;
    for (int i = 0; i < 7; i++) begin
      BF_val = 1'b1; BF_data = 8'($urandom); tick();
    end
    BF_val = 1'b0;
    layer_fnh = 1'b1; fnh_live = 1'b1;
    tick();
    layer_fnh = 1'b0; fnh_live = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_reset");
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    IFPOOL_rdy = 1'b1; dp0 = d_pops;
    for (int i = 0; i < 16; i++) begin
      BF_val = 1'b1; BF_data = 8'($urandom); tick();
    end
    BF_val = 1'b0;
    drain("t6");
    check("t6_pops", 128'(d_pops - dp0), 128'd1);
    check("t6_no_clear", 128'(clear_cnt - clr0), 128'd0);

    // 7: random traffic and backpressure, then flush with a beat in the fnh cycle
    clr0 = clear_cnt;
    for (int i = 0; i < 400; i++) begin
      BF_val = 1'($urandom_range(0, 1)); BF_data = 8'($urandom);
      BF_flg_val = 1'($urandom_range(0, 1)); BF_flg_data = $urandom;
      IFPOOL_rdy = 1'($urandom_range(0, 1)); IFPOOL_flg_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    BF_val = 1'b1; BF_data = 8'($urandom);
    BF_flg_val = 1'b1; BF_flg_data = $urandom;
    layer_fnh = 1'b1; fnh_live = 1'b1;
    tick();
    layer_fnh = 1'b0; fnh_live = 1'b0; BF_val = 1'b0; BF_flg_val = 1'b0;
    IFPOOL_rdy = 1'b1; IFPOOL_flg_rdy = 1'b1;
    g = 0;
    while (clear_cnt == clr0 && g < 100) begin
      tick(); g++;
    end
    check("t7_clear", 128'(clear_cnt - clr0), 128'd1);
    check("t7_all_popped", 128'(exp_d.size() + exp_f.size()), 128'd0);
    tick();
    check("t7_rdy", 128'(BF_rdy & BF_flg_rdy), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pool_out_packer.md
Name: pool_out_packer

Overview:
- Parametrised successor to the pooling output stage in the PEB.
- Packs the narrow pooled-data stream (DATA_WIDTH per beat) and the sparsity-flag stream (FLAG_WIDTH per beat) into PORT_WIDTH words for the interface block.
- Each path has its own output FIFO.
- On layer finish, zero-pads and flushes partial words, drains both FIFOs, then pulses clear_up to upstream.

Parameters:
- PORT_WIDTH, 128, output word width; must be a multiple of DATA_WIDTH and FLAG_WIDTH.
- DATA_WIDTH, 8, pooled data beat width.
- FLAG_WIDTH, 32, flag beat width.
- OUT_DEPTH, 2, entries per output FIFO; power of two, at least 1.
- DATA_LANES, PORT_WIDTH/DATA_WIDTH, derived localparam.
- FLAG_LANES, PORT_WIDTH/FLAG_WIDTH, derived localparam.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- layer_fnh  in  1  single-cycle pulse: layer finished.
- clear_up  out  1  single-cycle pulse: flush complete.
- BF_rdy  out  1  data beat ready.
- BF_val  in  1  data beat valid.
- BF_data  in  DATA_WIDTH  data beat.
- BF_flg_rdy  out  1  flag beat ready.
- BF_flg_val  in  1  flag beat valid.
- BF_flg_data  in  FLAG_WIDTH  flag beat.
- IFPOOL_rdy  in  1  downstream ready, data path.
- POOLIF_val  out  1  packed data word valid.
- POOLIF_data  out  PORT_WIDTH  packed data word.
- IFPOOL_flg_rdy  in  1  downstream ready, flag path.
- POOLIF_flg_val  out  1  packed flag word valid.
- POOLIF_flg_data  out  PORT_WIDTH  packed flag word.

Behaviour:
- Clocking and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values:
  - state RUN; lane counters 0; pack registers 0; FIFOs empty.
  - POOLIF_val=0, POOLIF_flg_val=0, both data outputs 0, clear_up=0.
  - BF_rdy=1, BF_flg_rdy=1 (RUN and FIFOs not full).
- Handshakes: a transfer occurs when val&rdy. Valid must not depend on ready.
- Data path packing:
  - Accepted beat is written to lane dcnt; lane 0 occupies the LSBs.
  - dcnt increments modulo DATA_LANES.
  - When the beat at lane DATA_LANES-1 is accepted, the completed word (including that beat) is pushed into the data FIFO and the pack register clears to 0.
- Flag path: identical, using fcnt, FLAG_LANES and the flag FIFO. The two paths are fully independent.
- Ready: BF_rdy = (state==RUN) & !data_fifo_full. BF_flg_rdy is the same using the flag FIFO.
- Output: POOLIF_val = !fifo_empty and POOLIF_data = FIFO head; pop on val&rdy.
  - Latency: the last lane accepted at cycle t gives valid at t+1.
  - Simultaneous push and pop on a full FIFO is not required; rdy is already low when full.
  - Data outputs hold the head slot value when not valid.
- FSM:
  - RUN: layer_fnh → FLUSH. A beat accepted in the same cycle as layer_fnh is included.
  - FLUSH: BF_rdy and BF_flg_rdy are 0.
    - If dcnt≠0 and the data FIFO is not full, push the zero-padded pack word and set dcnt=0. Same for the flag path.
    - When dcnt==0 and fcnt==0 → DRAIN. Minimum residence is one cycle.
  - DRAIN: wait until both FIFOs are empty → DONE.
  - DONE: clear_up=1 for this one cycle → RUN.
- layer_fnh outside RUN is ignored.
- Flush with no partial words: layer_fnh at t, clear_up at t+3 if both FIFOs are already empty.
- Reset mid-operation: partial words and FIFO contents are discarded; no clear_up is issued.

Optional Feature:
- Macro: POOL_OUT_STAT_EN.
- When defined, adds two ports:
  - stat_words  out  16  data words popped this layer.
  - stat_flg_words  out  16  flag words popped this layer.
- Counter rules: count increments on pop and saturates at 0xFFFF. Counters clear in the cycle after clear_up and on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pool_out_pkg holds:
  - state encoding RUN=2'd0, FLUSH=2'd1, DRAIN=2'd2, DONE=2'd3;
  - a clog2 function for counter and pointer widths.
- One natural sub-module: pool_out_fifo, a parametrised synchronous FIFO (width, depth) with full/empty flags. It is instantiated twice, once per path.

Test Plan:
1. Defaults, IFPOOL_rdy=1, bytes 0x00..0x0F back-to-back → one POOLIF word 0x0F0E0D0C0B0A09080706050403020100, valid the cycle after the 16th accept.
2. Flags 0x11111111, 0x22222222, 0x33333333, 0x44444444 → POOLIF_flg_data 0x44444444333333332222222211111111; the data path is unaffected.
3. IFPOOL_rdy=0, offer 48 bytes, OUT_DEPTH=2 → BF_rdy falls after byte 32. Raise IFPOOL_rdy → remaining 16 bytes accepted; 3 words out in order, no loss or duplication.
4. Bytes 0xA1..0xA5 plus one flag 0xDEADBEEF, then layer_fnh →
   - data word 0x…0000A5A4A3A2A1 (upper 11 bytes zero);
   - flag word 0x000…DEADBEEF;
   - clear_up once, after both words are popped;
   - BF_rdy low during FLUSH/DRAIN, 1 after.
5. layer_fnh with both paths empty and aligned → no output words; clear_up exactly at t+3. A second layer_fnh during DRAIN is ignored.
6. Assert rst_n low during FLUSH with a partial word → all outputs return to reset values immediately; no clear_up; the next 16 bytes produce a clean word.
